// File: rtl/fast_spi_tx_core.sv
// FIFO-fed SPI transmit serializer: pops 32-bit words and shifts them out MSB-first,
// chaining back-to-back words into one SEN frame with optional inter-frame gap.
module fast_spi_tx_core #(
  parameter int GAP_CYCLES      = 0,
  parameter int MAX_FRAME_WORDS = 0,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 FIFO_EMPTY,
  input  logic [31:0]          FIFO_DATA,
  output logic                 FIFO_READ,
  output logic                 SDO,
  output logic                 SEN,
  output logic                 SCLK_EN,
  output logic                 BUSY,
  output logic                 FRAME_DONE,
  output logic [CNT_WIDTH-1:0] WORD_CNT
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [31:0] MAX_W = 32'(MAX_FRAME_WORDS);
  localparam logic [7:0]  GAP_W = 8'(GAP_CYCLES);

  state_t                 state_q, state_d;
  logic [31:0]            shreg_q;
  logic [4:0]             bitcnt_q;
  logic [31:0]            fwc_q;
  logic [7:0]             gap_q;
  logic                   sen_q, sdo_q, done_q;
  logic [CNT_WIDTH-1:0]   wcnt_q;
  logic                   last_bit, chain;

  assign last_bit = (state_q == SHIFT) && (bitcnt_q == 5'd31);
  assign chain    = EN && !FIFO_EMPTY && ((MAX_W == 32'd0) || (fwc_q < MAX_W));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (FIFO_READ) state_d = SHIFT;
      SHIFT: if (last_bit && !chain) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:   if (gap_q <= 8'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pop strobe is combinational and held low while reset is asserted.
  always_comb begin
    FIFO_READ = 1'b0;
    BUSY      = (state_q != IDLE);
    if (!RST) begin
      case (state_q)
        IDLE:    FIFO_READ = EN && !FIFO_EMPTY;
        SHIFT:   FIFO_READ = last_bit && chain;
        default: FIFO_READ = 1'b0;
      endcase
    end
  end

  // SDO/SEN are registered so bit 0 of a word leaves one cycle after its pop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      fwc_q    <= '0;
      gap_q    <= '0;
      sen_q    <= 1'b0;
      sdo_q    <= 1'b0;
      done_q   <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (FIFO_READ) begin
        shreg_q  <= FIFO_DATA;
        bitcnt_q <= 5'd0;
        fwc_q    <= fwc_q + 32'd1;
        sen_q    <= 1'b1;
        sdo_q    <= FIFO_DATA[31];
      end else if (state_q == SHIFT) begin
        shreg_q  <= {shreg_q[30:0], shreg_q[31]};
        bitcnt_q <= bitcnt_q + 5'd1;
        sdo_q    <= shreg_q[30];
        if (last_bit) begin
          sen_q  <= 1'b0;
          sdo_q  <= 1'b0;
          done_q <= 1'b1;
          fwc_q  <= 32'd0;
          gap_q  <= GAP_W;
        end
      end else if (state_q == GAP) begin
        gap_q <= gap_q - 8'd1;
      end
      if (last_bit) wcnt_q <= wcnt_q + CNT_WIDTH'(1);
    end
  end

  assign SDO        = sdo_q;
  assign SEN        = sen_q;
  assign SCLK_EN    = sen_q;
  assign FRAME_DONE = done_q;
  assign WORD_CNT   = wcnt_q;

endmodule

// File: tb/tb_fast_spi_tx_core.sv
// Directed bench for fast_spi_tx_core: three instances cover default, frame-limit/gap
// and narrow-counter configurations, each fed by a small FIFO model.
module tb_fast_spi_tx_core;

  logic        clk = 1'b0;
  logic [2:0]  rst = 3'b111;
  logic [2:0]  en  = 3'b000;
  logic [2:0]  femp;
  logic [31:0] fdata [3];
  logic [2:0]  rd, sdo, sen, sclk, busy, done;
  logic [15:0] wc0, wc1;
  logic [3:0]  wc2;

  logic [31:0] mem [3][32];
  int          wp [3];
  int          rp [3];

  int n_checks = 0;
  int n_fail   = 0;

  bit tr_sen [256];
  bit tr_sdo [256];
  bit tr_rd  [256];
  bit tr_done[256];
  bit tr_sclk[256];
  bit tr_busy[256];

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 3; i++) begin
      wp[i] = 0;
      rp[i] = 0;
    end
  end

  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (rd[i]) rp[i] <= rp[i] + 1;

  always_comb
    for (int i = 0; i < 3; i++) begin
      femp[i]  = (wp[i] == rp[i]);
      fdata[i] = mem[i][rp[i] % 32];
    end

  fast_spi_tx_core #(.GAP_CYCLES(0), .MAX_FRAME_WORDS(0), .CNT_WIDTH(16)) u0 (
    .CLK(clk), .RST(rst[0]), .EN(en[0]), .FIFO_EMPTY(femp[0]), .FIFO_DATA(fdata[0]),
    .FIFO_READ(rd[0]), .SDO(sdo[0]), .SEN(sen[0]), .SCLK_EN(sclk[0]), .BUSY(busy[0]),
    .FRAME_DONE(done[0]), .WORD_CNT(wc0));

  fast_spi_tx_core #(.GAP_CYCLES(4), .MAX_FRAME_WORDS(2), .CNT_WIDTH(16)) u1 (
    .CLK(clk), .RST(rst[1]), .EN(en[1]), .FIFO_EMPTY(femp[1]), .FIFO_DATA(fdata[1]),
    .FIFO_READ(rd[1]), .SDO(sdo[1]), .SEN(sen[1]), .SCLK_EN(sclk[1]), .BUSY(busy[1]),
    .FRAME_DONE(done[1]), .WORD_CNT(wc1));

  fast_spi_tx_core #(.GAP_CYCLES(0), .MAX_FRAME_WORDS(0), .CNT_WIDTH(4)) u2 (
    .CLK(clk), .RST(rst[2]), .EN(en[2]), .FIFO_EMPTY(femp[2]), .FIFO_DATA(fdata[2]),
    .FIFO_READ(rd[2]), .SDO(sdo[2]), .SEN(sen[2]), .SCLK_EN(sclk[2]), .BUSY(busy[2]),
    .FRAME_DONE(done[2]), .WORD_CNT(wc2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [31:0] w);
    mem[idx][wp[idx] % 32] = w;
    wp[idx]++;
  endtask

  task automatic do_reset(input int idx);
    en[idx]  = 1'b0;
    rst[idx] = 1'b1;
    #1;
    wp[idx] = rp[idx];
  endtask

  task automatic release_rst(input int idx);
    rst[idx] = 1'b0;
    #1;
  endtask

  task automatic capture(input int idx, input int n, input int drop_at);
    for (int c = 0; c < n; c++) begin
      if (c == drop_at) begin
        en[idx] = 1'b0;
        #1;
      end
      tr_sen[c]  = sen[idx];
      tr_sdo[c]  = sdo[idx];
      tr_rd[c]   = rd[idx];
      tr_done[c] = done[idx];
      tr_sclk[c] = sclk[idx];
      tr_busy[c] = busy[idx];
      tick();
    end
  endtask

  function automatic int cnt(input int sel, input int n);
    int s = 0;
    for (int c = 0; c < n; c++)
      case (sel)
        0: s += int'(tr_sen[c]);
        1: s += int'(tr_rd[c]);
        2: s += int'(tr_done[c]);
        default: s += int'(tr_sen[c] != tr_sclk[c]);
      endcase
    return s;
  endfunction

  function automatic int find_sen(input int start, input bit val);
    for (int c = start; c < 256; c++)
      if (tr_sen[c] == val) return c;
    return -1;
  endfunction

  function automatic logic [31:0] sdo_word(input int start);
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) w[31-i] = tr_sdo[start+i];
    return w;
  endfunction

  initial begin
    tick();

    // Reset state with a word waiting and EN high: nothing may move.
    do_reset(0);
    push(0, 32'hA5A50F0F);
    en[0] = 1'b1;
    #1;
    check("rst_sen",   32'(sen[0]),  0);
    check("rst_sdo",   32'(sdo[0]),  0);
    check("rst_sclk",  32'(sclk[0]), 0);
    check("rst_busy",  32'(busy[0]), 0);
    check("rst_done",  32'(done[0]), 0);
    check("rst_read",  32'(rd[0]),   0);
    check("rst_wcnt",  32'(wc0),     0);
    tick();

    // Single word.
    release_rst(0);
    capture(0, 40, -1);
    check("t1_rd0",    32'(tr_rd[0]),     1);
    check("t1_rdcnt",  cnt(1, 40),        1);
    check("t1_sen0",   32'(tr_sen[0]),    0);
    check("t1_rise",   find_sen(1, 1'b1), 1);
    check("t1_fall",   find_sen(1, 1'b0), 33);
    check("t1_sdo",    sdo_word(1),       32'hA5A50F0F);
    check("t1_sclk",   cnt(3, 40),        0);
    check("t1_done33", 32'(tr_done[33]),  1);
    check("t1_donecnt", cnt(2, 40),       1);
    check("t1_busy0",  32'(tr_busy[0]),   0);
    check("t1_busy1",  32'(tr_busy[1]),   1);
    check("t1_busy34", 32'(tr_busy[34]),  0);
    check("t1_wcnt",   32'(wc0),          1);

    // Back-to-back chain of three words.
    do_reset(0);
    tick();
    push(0, 32'hFFFFFFFF);
    push(0, 32'h00000000);
    push(0, 32'h80000001);
    en[0] = 1'b1;
    release_rst(0);
    capture(0, 110, -1);
    check("t2_rdcnt",  cnt(1, 110),       3);
    check("t2_rd32",   32'(tr_rd[32]),    1);
    check("t2_rd64",   32'(tr_rd[64]),    1);
    check("t2_sencnt", cnt(0, 110),       96);
    check("t2_rise",   find_sen(0, 1'b1), 1);
    check("t2_fall",   find_sen(1, 1'b0), 97);
    check("t2_w0",     sdo_word(1),       32'hFFFFFFFF);
    check("t2_w1",     sdo_word(33),      32'h00000000);
    check("t2_w2",     sdo_word(65),      32'h80000001);
    check("t2_donecnt", cnt(2, 110),      1);
    check("t2_done97", 32'(tr_done[97]),  1);
    check("t2_wcnt",   32'(wc0),          3);

    // EN drops at bit 10 of the first word.
    do_reset(0);
    tick();
    push(0, 32'h13579BDF);
    push(0, 32'h2468ACE0);
    push(0, 32'hDEADBEEF);
    en[0] = 1'b1;
    release_rst(0);
    capture(0, 60, 11);
    check("t4_rdcnt",  cnt(1, 60),        1);
    check("t4_sencnt", cnt(0, 60),        32);
    check("t4_sdo",    sdo_word(1),       32'h13579BDF);
    check("t4_donecnt", cnt(2, 60),       1);
    check("t4_wcnt",   32'(wc0),          1);
    en[0] = 1'b1;
    #1;
    capture(0, 40, -1);
    check("t4_resume_rd", 32'(tr_rd[0]),  1);
    check("t4_resume_w",  sdo_word(1),    32'h2468ACE0);
    check("t4_wcnt2",  32'(wc0),          2);

    // Asynchronous reset at bit 15.
    do_reset(0);
    tick();
    push(0, 32'hFFFFFFFF);
    push(0, 32'h12345678);
    en[0] = 1'b1;
    release_rst(0);
    for (int i = 0; i < 16; i++) tick();
    check("t5_pre_sen", 32'(sen[0]),      1);
    check("t5_pre_sdo", 32'(sdo[0]),      1);
    rst[0] = 1'b1;
    #1;
    check("t5_sen",    32'(sen[0]),       0);
    check("t5_sdo",    32'(sdo[0]),       0);
    check("t5_sclk",   32'(sclk[0]),      0);
    check("t5_busy",   32'(busy[0]),      0);
    check("t5_wcnt",   32'(wc0),          0);
    tick();
    check("t5_nodone", 32'(done[0]),      0);
    release_rst(0);
    capture(0, 40, -1);
    check("t5_rd0",    32'(tr_rd[0]),     1);
    check("t5_next",   sdo_word(1),       32'h12345678);
    check("t5_donecnt", cnt(2, 40),       1);
    check("t5_wcnt2",  32'(wc0),          1);

    // Frame limit of two words with a four-cycle gap.
    do_reset(1);
    tick();
    push(1, 32'h11111111);
    push(1, 32'h22222222);
    push(1, 32'hC3C3C3C3);
    push(1, 32'h44444444);
    en[1] = 1'b1;
    release_rst(1);
    capture(1, 150, -1);
    check("t3_rdcnt",  cnt(1, 150),       4);
    check("t3_rd32",   32'(tr_rd[32]),    1);
    check("t3_rd69",   32'(tr_rd[69]),    1);
    check("t3_rd101",  32'(tr_rd[101]),   1);
    check("t3_r1",     find_sen(0, 1'b1), 1);
    check("t3_f1",     find_sen(1, 1'b0), 65);
    check("t3_r2",     find_sen(65, 1'b1), 70);
    check("t3_f2",     find_sen(70, 1'b0), 134);
    check("t3_gapbusy", 32'(tr_busy[66]), 1);
    check("t3_w3",     sdo_word(70),      32'hC3C3C3C3);
    check("t3_donecnt", cnt(2, 150),      2);
    check("t3_done65", 32'(tr_done[65]),  1);
    check("t3_wcnt",   32'(wc1),          4);

    // Four-bit word counter wrap over 17 chained words.
    do_reset(2);
    tick();
    for (int i = 0; i < 17; i++) push(2, 32'(i * 32'h01010101));
    en[2] = 1'b1;
    release_rst(2);
    for (int c = 0; c <= 545; c++) begin
      if (c == 480) check("t6_w14", 32'(wc2), 14);
      if (c == 481) check("t6_w15", 32'(wc2), 15);
      if (c == 513) check("t6_w16", 32'(wc2), 0);
      if (c == 545) check("t6_w17", 32'(wc2), 1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fast_spi_tx_core.md
Name: fast_spi_tx_core

Overview:
- FIFO-fed serializer: pops 32-bit words from a first-word-fall-through FIFO and shifts them out MSB-first on SDO, framed by SEN.
- It is the transmit counterpart of fast_spi_rx. SEN/SDO feed the chip or a loop-back into fast_spi_rx.
- SCLK_EN drives the CE of an ODDR clock forwarder clocked by CLK. The receiver samples on ~CLK.
- Sits between the bus-side command FIFO and the pads, in the SPI clock domain.

Parameters:
- GAP_CYCLES, 0, minimum extra idle cycles with SEN low between two frames (0..255).
- MAX_FRAME_WORDS, 0, maximum words chained into one SEN frame; 0 means unlimited.
- CNT_WIDTH, 16, width of WORD_CNT.

Ports:
- CLK  input  1  shift clock; all logic on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  transmit enable; level sensitive.
- FIFO_EMPTY  input  1  source FIFO empty flag.
- FIFO_DATA  input  32  source FIFO head word; valid whenever FIFO_EMPTY=0.
- FIFO_READ  output  1  pop strobe; one cycle per word.
- SDO  output  1  serial data.
- SEN  output  1  frame enable; high while bits are valid.
- SCLK_EN  output  1  ODDR clock-enable; identical to SEN.
- BUSY  output  1  high in any state other than IDLE.
- FRAME_DONE  output  1  one-cycle pulse in the cycle after SEN falls.
- WORD_CNT  output  CNT_WIDTH  total words shifted out; wraps.

Behaviour:
- Interface: one clock, CLK; reset RST is asynchronous and active-high.
- Reset values: FIFO_READ, SDO, SEN, SCLK_EN, BUSY and FRAME_DONE are all 0; WORD_CNT=0; state=IDLE; shift register and bit counter are 0.
- States: IDLE, SHIFT, GAP.
- FIFO_READ is combinational. It is asserted only:
  - in IDLE when EN=1 and FIFO_EMPTY=0;
  - in SHIFT on bit 31 when the chain condition holds.
- On every clock edge with FIFO_READ=1: shift register <= FIFO_DATA; bit counter <= 0; frame word count incremented.
- IDLE -> SHIFT on the pop edge.
- Latency: pop in cycle k. SEN, SCLK_EN and SDO are registered, so bit i (bit 31-i of the word) appears on SDO in cycle k+1+i, and SEN=1 in cycles k+1..k+32.
- SHIFT: SDO = current MSB; shift left each cycle; bit counter 0..31.
- WORD_CNT increments by 1 on the edge ending bit 31 and wraps modulo 2^CNT_WIDTH.
- Chain condition, evaluated on bit 31: EN=1, FIFO_EMPTY=0, and either MAX_FRAME_WORDS=0 or frame word count < MAX_FRAME_WORDS.
  - If true: pop, stay in SHIFT; SEN stays high with no bubble (N chained words give 32*N contiguous SEN cycles).
  - If false: SEN falls after bit 31 and FRAME_DONE pulses. Go to GAP if GAP_CYCLES>0, else IDLE; frame word count cleared.
- Frame spacing:
  - With GAP_CYCLES=0 the minimum SEN-low time between frames is 1 cycle (the IDLE pop cycle).
  - With GAP_CYCLES=G it is G+1 cycles.
- GAP: down-counter from GAP_CYCLES; FIFO_READ=0 regardless of EN/FIFO; go to IDLE when it reaches 1.
- EN deasserted mid-word: the current word completes all 32 bits, then the frame ends (no chain).
- EN reasserted during GAP: no effect until IDLE.
- FIFO_EMPTY asserting mid-word: no effect until bit 31 (the word is already latched).
- RST mid-operation: all outputs drop immediately (asynchronously). The popped word is discarded; it is not re-read and not counted.
- FRAME_DONE is never asserted for a word aborted by reset.
- SCLK_EN equals SEN bit-for-bit, so a forwarded clock edge exists only for valid bits.

Test Plan:
- Single word:
  - Stimulus: GAP=0, FIFO holds 0xA5A50F0F, EN=1.
  - Response: FIFO_READ high 1 cycle; next cycle SEN high for 32 cycles; SDO = 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1,0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1; FRAME_DONE pulses; WORD_CNT=1.
- Back-to-back:
  - Stimulus: 3 words 0xFFFFFFFF, 0x00000000, 0x80000001.
  - Response: SEN contiguous for 96 cycles; FIFO_READ pulses exactly 32 cycles apart; WORD_CNT=3; one FRAME_DONE.
- Frame limit and gap:
  - Stimulus: MAX_FRAME_WORDS=2, GAP_CYCLES=4, 4 words queued.
  - Response: two 64-cycle SEN frames separated by exactly 5 SEN-low cycles; 2 FRAME_DONE pulses.
- EN drop:
  - Stimulus: EN low at bit 10 of word 1, 3 words queued.
  - Response: word 1 completes all 32 bits; no further FIFO_READ; WORD_CNT=1; re-raising EN resumes with word 2.
- Reset mid-shift:
  - Stimulus: RST pulse at bit 15.
  - Response: SEN, SDO and SCLK_EN go 0 in the same cycle (asynchronous); WORD_CNT=0; no FRAME_DONE; after release the next queued word transmits normally.
- Counter wrap:
  - Stimulus: CNT_WIDTH=4, 17 words.
  - Response: WORD_CNT reads 15 after word 15, 0 after word 16, 1 after word 17.
